// File: rtl/pss_tracker_pkg.sv
// Shared PSS search/track definitions, used by the tracker and the PSS detector.
package pss_tracker_pkg;

  localparam int SSB_INTERVAL_DEFAULT = 38400;

  localparam logic [1:0] MODE_SEARCH = 2'd0;
  localparam logic [1:0] MODE_FIND   = 2'd1;
  localparam logic [1:0] MODE_PAUSE  = 2'd2;

  function automatic logic is_tracking(input logic [1:0] mode);
    return (mode == MODE_FIND) || (mode == MODE_PAUSE);
  endfunction

endpackage

// File: rtl/pss_tracker_sat_accumulator.sv
// Signed accumulator that clips to the representable range instead of wrapping.
module sat_accumulator #(
  parameter int W = 20
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                clear_i,
  input  logic                add_valid_i,
  input  logic signed [W-1:0] add_i,
  output logic signed [W-1:0] acc_o
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic [W:0] sum_s;
    sum_s = {a[W-1], a} + {b[W-1], b};
    if (sum_s[W] != sum_s[W-1]) begin
      sat_add = sum_s[W] ? MIN_V : MAX_V;
    end else begin
      sat_add = sum_s[W-1:0];
    end
  endfunction

  logic signed [W-1:0] acc_r;

  // Accumulator register; a clear wins over a same-cycle add.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_r <= {W{1'b0}};
    end else if (clear_i) begin
      acc_r <= {W{1'b0}};
    end else if (add_valid_i) begin
      acc_r <= sat_add(acc_r, add_i);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc_o = acc_r;

endmodule

// File: rtl/pss_tracker.sv
// Tracks the periodic PSS burst: acquires on a detection, then gates the detector
// into a window around each expected burst and declares lock after repeated hits.
module pss_tracker
  import pss_tracker_pkg::*;
#(
  parameter int SSB_INTERVAL    = SSB_INTERVAL_DEFAULT,
  parameter int TRACK_TOLERANCE = 100,
  parameter int LOCK_HITS       = 2,
  parameter int MAX_MISSES      = 3,
  parameter int DDS_DW          = 20
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     s_axis_in_tvalid,
  input  logic [1:0]               N_id_2_i,
  input  logic                     N_id_2_valid_i,
  input  logic signed [DDS_DW-1:0] CFO_DDS_inc_i,
  input  logic                     CFO_valid_i,
  output logic [1:0]               mode_o,
  output logic [1:0]               requested_N_id_2_o,
  output logic                     locked_o,
  output logic                     SSB_start_o,
  output logic signed [DDS_DW-1:0] CFO_DDS_inc_o
);

  localparam int CNT_W  = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1);
  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FIND_START = CNT_W'(SSB_INTERVAL - TRACK_TOLERANCE);
  localparam logic [CNT_W-1:0]  WIN_END    = CNT_W'(SSB_INTERVAL + TRACK_TOLERANCE);
  localparam logic [CNT_W-1:0]  CNT_REARM  = CNT_W'(TRACK_TOLERANCE);
  localparam logic [HIT_W-1:0]  HITS_ZERO  = {HIT_W{1'b0}};
  localparam logic [HIT_W-1:0]  HITS_ONE   = HIT_W'(1);
  localparam logic [HIT_W-1:0]  HITS_SAT   = HIT_W'(LOCK_HITS);
  localparam logic [MISS_W-1:0] MISS_ZERO  = {MISS_W{1'b0}};
  localparam logic [MISS_W-1:0] MISS_ONE   = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [HIT_W-1:0]  hits_r;
  logic [HIT_W-1:0]  hits_nxt_s;
  logic [MISS_W-1:0] miss_r;
  logic [MISS_W-1:0] miss_nxt_s;
  logic [MISS_W-1:0] miss_inc_s;
  logic [1:0]        req_id_r;
  logic [1:0]        req_id_nxt_s;
  logic              accept_s;
  logic              search_entry_s;
  logic              id_match_s;
  logic              win_end_s;
  logic              locked_r;
  logic              ssb_start_r;

  // Sample counting only advances on qualified samples, so timing follows the sample rate.
  assign cnt_inc_s  = s_axis_in_tvalid ? (cnt_r + CNT_ONE) : cnt_r;
  assign miss_inc_s = miss_r + MISS_ONE;
  assign id_match_s = N_id_2_valid_i && (N_id_2_i == req_id_r);
  assign win_end_s  = s_axis_in_tvalid && (cnt_inc_s == WIN_END);

  // Next-state logic for the search / pause / find tracker.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    hits_nxt_s     = hits_r;
    miss_nxt_s     = miss_r;
    req_id_nxt_s   = req_id_r;
    accept_s       = 1'b0;
    search_entry_s = 1'b0;
    case (state_r)
      MODE_SEARCH: begin
        if (N_id_2_valid_i) begin
          req_id_nxt_s = N_id_2_i;
          cnt_nxt_s    = CNT_ZERO;
          hits_nxt_s   = HITS_ONE;
          miss_nxt_s   = MISS_ZERO;
          accept_s     = 1'b1;
          state_nxt_s  = MODE_PAUSE;
        end else begin
          cnt_nxt_s    = CNT_ZERO;
          state_nxt_s  = MODE_SEARCH;
        end
      end
      MODE_PAUSE: begin
        cnt_nxt_s = cnt_inc_s;
        if (s_axis_in_tvalid && (cnt_inc_s == FIND_START)) begin
          state_nxt_s = MODE_FIND;
        end else begin
          state_nxt_s = MODE_PAUSE;
        end
      end
      MODE_FIND: begin
        // A hit on the window-end sample still counts as a hit.
        if (id_match_s) begin
          cnt_nxt_s   = CNT_ZERO;
          miss_nxt_s  = MISS_ZERO;
          hits_nxt_s  = (hits_r == HITS_SAT) ? hits_r : (hits_r + HITS_ONE);
          accept_s    = 1'b1;
          state_nxt_s = MODE_PAUSE;
        end else if (win_end_s) begin
          hits_nxt_s = HITS_ZERO;
          if (miss_inc_s == MISS_LIMIT) begin
            cnt_nxt_s      = CNT_ZERO;
            miss_nxt_s     = MISS_ZERO;
            search_entry_s = 1'b1;
            state_nxt_s    = MODE_SEARCH;
          end else begin
            // Rearm at the tolerance offset so the next window stays on the nominal grid.
            cnt_nxt_s   = CNT_REARM;
            miss_nxt_s  = miss_inc_s;
            state_nxt_s = MODE_PAUSE;
          end
        end else begin
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = MODE_FIND;
        end
      end
      default: begin
        cnt_nxt_s      = CNT_ZERO;
        hits_nxt_s     = HITS_ZERO;
        miss_nxt_s     = MISS_ZERO;
        search_entry_s = 1'b1;
        state_nxt_s    = MODE_SEARCH;
      end
    endcase
  end

  // Tracker state, counters and the detection pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r     <= MODE_SEARCH;
      cnt_r       <= CNT_ZERO;
      hits_r      <= HITS_ZERO;
      miss_r      <= MISS_ZERO;
      req_id_r    <= 2'd0;
      ssb_start_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hits_r      <= hits_nxt_s;
      miss_r      <= miss_nxt_s;
      req_id_r    <= req_id_nxt_s;
      ssb_start_r <= accept_s;
    end
  end

  // Lock is sticky while tracking and drops only on a return to search.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      locked_r <= 1'b0;
    end else if (search_entry_s) begin
      locked_r <= 1'b0;
    end else if (is_tracking(state_r) && (hits_r == HITS_SAT)) begin
      locked_r <= 1'b1;
    end else begin
      locked_r <= locked_r;
    end
  end

  sat_accumulator #(
    .W (DDS_DW)
  ) u_cfo_acc (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .clear_i     (search_entry_s),
    .add_valid_i (CFO_valid_i),
    .add_i       (CFO_DDS_inc_i),
    .acc_o       (CFO_DDS_inc_o)
  );

  assign mode_o             = state_r;
  assign requested_N_id_2_o = req_id_r;
  assign locked_o           = locked_r;
  assign SSB_start_o        = ssb_start_r;

endmodule

// File: tb/tb_pss_tracker.sv
// Scenario bench for pss_tracker with a shortened SSB interval; accepted detections
// are scoreboarded against the SSB_start_o pulses.
module tb_pss_tracker;
  import pss_tracker_pkg::*;

  localparam int SSB = 400;
  localparam int TOL = 20;
  localparam int LH  = 2;
  localparam int MM  = 3;
  localparam int DW  = 20;

  logic                 clk;
  logic                 rst_n;
  logic                 tvalid;
  logic [1:0]           det_id;
  logic                 det_vld;
  logic signed [DW-1:0] cfo_inc;
  logic                 cfo_vld;
  logic [1:0]           mode;
  logic [1:0]           req_id;
  logic                 locked;
  logic                 ssb_start;
  logic signed [DW-1:0] cfo_acc;

  int         n_vec;
  int         n_err;
  logic [1:0] exp_q[$];
  logic [1:0] exp_id;

  pss_tracker #(
    .SSB_INTERVAL    (SSB),
    .TRACK_TOLERANCE (TOL),
    .LOCK_HITS       (LH),
    .MAX_MISSES      (MM),
    .DDS_DW          (DW)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (rst_n),
    .s_axis_in_tvalid   (tvalid),
    .N_id_2_i           (det_id),
    .N_id_2_valid_i     (det_vld),
    .CFO_DDS_inc_i      (cfo_inc),
    .CFO_valid_i        (cfo_vld),
    .mode_o             (mode),
    .requested_N_id_2_o (req_id),
    .locked_o           (locked),
    .SSB_start_o        (ssb_start),
    .CFO_DDS_inc_o      (cfo_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each SSB_start_o pulse must match the oldest accepted detection.
  always @(negedge clk) begin
    if (rst_n && ssb_start) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: SSB_start_o=1 with no accepted detection pending");
      end else begin
        exp_id = exp_q.pop_front();
        if (req_id !== exp_id) begin
          n_err++;
          $display("FAIL sb_req_id: requested_N_id_2_o=%0d expected %0d", req_id, exp_id);
        end
      end
    end
  end

  task automatic step(input logic tv, input logic det, input logic [1:0] id,
                      input logic cv, input logic signed [DW-1:0] inc);
    tvalid  = tv;
    det_vld = det;
    det_id  = id;
    cfo_vld = cv;
    cfo_inc = inc;
    @(posedge clk);
    #1;
    tvalid  = 1'b0;
    det_vld = 1'b0;
    cfo_vld = 1'b0;
  endtask

  task automatic run_samples(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 20'sd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({mode, req_id, locked, ssb_start} !== 6'b0 || cfo_acc !== 20'sd0) begin
      n_err++;
      $display("FAIL reset_vals: mode=%0d req=%0d lock=%0b ssb=%0b cfo=%0d expected all 0",
               mode, req_id, locked, ssb_start, cfo_acc);
    end
    rst_n = 1'b1;
    run_samples(5, 0);
    n_vec++;
    if (mode !== MODE_SEARCH || ssb_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: mode=%0d ssb=%0b expected 0/0", mode, ssb_start);
    end
  endtask

  task automatic test_search_find();
    exp_q.push_back(2'd1);
    step(1'b1, 1'b1, 2'd1, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b1 || mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t1_accept: ssb=%0b mode=%0d expected 1/%0d", ssb_start, mode, MODE_PAUSE);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b0) begin
      n_err++;
      $display("FAIL t1_pulse_width: ssb=%0b expected 0", ssb_start);
    end
    run_samples(SSB - TOL - 1, 0);
    n_vec++;
    if (mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t1_pause_hold: mode=%0d expected %0d", mode, MODE_PAUSE);
    end
    run_samples(1, 0);
    n_vec++;
    if (mode !== MODE_FIND) begin
      n_err++;
      $display("FAIL t1_find_open: mode=%0d expected %0d", mode, MODE_FIND);
    end
  endtask

  task automatic test_lock();
    run_samples(TOL - 1, 0);
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL t2_prelock: locked=%0b expected 0", locked);
    end
    exp_q.push_back(2'd1);
    step(1'b1, 1'b1, 2'd1, 1'b1, 20'sd12345);
    n_vec++;
    if (ssb_start !== 1'b1 || mode !== MODE_PAUSE || locked !== 1'b0) begin
      n_err++;
      $display("FAIL t2_hit: ssb=%0b mode=%0d lock=%0b expected 1/%0d/0",
               ssb_start, mode, locked, MODE_PAUSE);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    n_vec++;
    if (locked !== 1'b1 || req_id !== 2'd1 || cfo_acc !== 20'sd12345) begin
      n_err++;
      $display("FAIL t2_locked: lock=%0b req=%0d cfo=%0d expected 1/1/12345",
               locked, req_id, cfo_acc);
    end
  endtask

  task automatic test_miss_to_search();
    run_samples(SSB + TOL - 1, 0);
    n_vec++;
    if (mode !== MODE_FIND) begin
      n_err++;
      $display("FAIL t3_pre_close1: mode=%0d expected %0d", mode, MODE_FIND);
    end
    run_samples(1, 0);
    n_vec++;
    if (mode !== MODE_PAUSE || locked !== 1'b1) begin
      n_err++;
      $display("FAIL t3_close1: mode=%0d lock=%0b expected %0d/1", mode, locked, MODE_PAUSE);
    end
    run_samples(SSB - 2 * TOL - 1, 0);
    n_vec++;
    if (mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t3_rearm_hold: mode=%0d expected %0d", mode, MODE_PAUSE);
    end
    run_samples(1, 0);
    n_vec++;
    if (mode !== MODE_FIND) begin
      n_err++;
      $display("FAIL t3_rearm_find: mode=%0d expected %0d", mode, MODE_FIND);
    end
    run_samples(2 * TOL - 1, 0);
    run_samples(1, 0);
    n_vec++;
    if (mode !== MODE_PAUSE || locked !== 1'b1) begin
      n_err++;
      $display("FAIL t3_close2: mode=%0d lock=%0b expected %0d/1", mode, locked, MODE_PAUSE);
    end
    run_samples(SSB - 1, 0);
    n_vec++;
    if (mode !== MODE_FIND || cfo_acc !== 20'sd12345) begin
      n_err++;
      $display("FAIL t3_pre_close3: mode=%0d cfo=%0d expected %0d/12345", mode, cfo_acc, MODE_FIND);
    end
    step(1'b1, 1'b0, 2'd0, 1'b1, 20'sd77);
    n_vec++;
    if (mode !== MODE_SEARCH || locked !== 1'b0 || cfo_acc !== 20'sd0) begin
      n_err++;
      $display("FAIL t3_to_search: mode=%0d lock=%0b cfo=%0d expected %0d/0/0",
               mode, locked, cfo_acc, MODE_SEARCH);
    end
  endtask

  task automatic test_wrong_id_edge_hit();
    exp_q.push_back(2'd1);
    step(1'b1, 1'b1, 2'd1, 1'b0, 20'sd0);
    run_samples(SSB - TOL, 0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b0 || mode !== MODE_FIND || req_id !== 2'd1) begin
      n_err++;
      $display("FAIL t4_wrong_id: ssb=%0b mode=%0d req=%0d expected 0/%0d/1",
               ssb_start, mode, req_id, MODE_FIND);
    end
    run_samples(2 * TOL - 2, 0);
    exp_q.push_back(2'd1);
    step(1'b1, 1'b1, 2'd1, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b1 || mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t4_edge_hit: ssb=%0b mode=%0d expected 1/%0d", ssb_start, mode, MODE_PAUSE);
    end
    run_samples(100, 0);
    step(1'b1, 1'b1, 2'd1, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b0 || mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t4_pause_ignore: ssb=%0b mode=%0d expected 0/%0d", ssb_start, mode, MODE_PAUSE);
    end
    run_samples(SSB - TOL - 102, 0);
    n_vec++;
    if (mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t4_hit_timing_hold: mode=%0d expected %0d", mode, MODE_PAUSE);
    end
    run_samples(1, 0);
    n_vec++;
    if (mode !== MODE_FIND) begin
      n_err++;
      $display("FAIL t4_hit_timing_find: mode=%0d expected %0d", mode, MODE_FIND);
    end
  endtask

  task automatic test_cfo_sat();
    step(1'b0, 1'b0, 2'd0, 1'b1, 20'sd524278);
    n_vec++;
    if (cfo_acc !== 20'sd524278) begin
      n_err++;
      $display("FAIL t5_first_add: cfo=%0d expected 524278", cfo_acc);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, 20'sd100);
    n_vec++;
    if (cfo_acc !== 20'sd524287) begin
      n_err++;
      $display("FAIL t5_pos_sat: cfo=%0d expected 524287", cfo_acc);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, -20'sd5);
    n_vec++;
    if (cfo_acc !== 20'sd524282) begin
      n_err++;
      $display("FAIL t5_after_sat: cfo=%0d expected 524282", cfo_acc);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, 20'h80000);
    n_vec++;
    if (cfo_acc !== -20'sd6) begin
      n_err++;
      $display("FAIL t5_neg_add: cfo=%0d expected -6", cfo_acc);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, 20'h80000);
    n_vec++;
    if (cfo_acc !== 20'h80000) begin
      n_err++;
      $display("FAIL t5_neg_sat: cfo=%0d expected -524288", cfo_acc);
    end
  endtask

  task automatic test_duty_and_reset();
    rst_n = 1'b0;
    exp_q.delete();
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    exp_q.push_back(2'd3);
    step(1'b1, 1'b1, 2'd3, 1'b0, 20'sd0);
    run_samples(SSB - TOL - 1, 3);
    repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    n_vec++;
    if (mode !== MODE_PAUSE) begin
      n_err++;
      $display("FAIL t6_duty_hold: mode=%0d expected %0d", mode, MODE_PAUSE);
    end
    run_samples(1, 3);
    n_vec++;
    if (mode !== MODE_FIND || req_id !== 2'd3) begin
      n_err++;
      $display("FAIL t6_duty_find: mode=%0d req=%0d expected %0d/3", mode, req_id, MODE_FIND);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, 20'sd500);
    tvalid  = 1'b1;
    det_vld = 1'b1;
    det_id  = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mode, req_id, locked, ssb_start} !== 6'b0 || cfo_acc !== 20'sd0) begin
      n_err++;
      $display("FAIL t6_async_reset: mode=%0d req=%0d lock=%0b ssb=%0b cfo=%0d expected all 0",
               mode, req_id, locked, ssb_start, cfo_acc);
    end
    @(posedge clk);
    #1;
    tvalid  = 1'b0;
    det_vld = 1'b0;
    rst_n   = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 20'sd0);
    n_vec++;
    if (ssb_start !== 1'b0 || mode !== MODE_SEARCH || req_id !== 2'd0 || cfo_acc !== 20'sd0) begin
      n_err++;
      $display("FAIL t6_post_reset: ssb=%0b mode=%0d req=%0d cfo=%0d expected 0/0/0/0",
               ssb_start, mode, req_id, cfo_acc);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    tvalid  = 1'b0;
    det_vld = 1'b0;
    det_id  = 2'd0;
    cfo_vld = 1'b0;
    cfo_inc = 20'sd0;
    test_reset();
    test_search_find();
    test_lock();
    test_miss_to_search();
    test_wrong_id_edge_hit();
    test_cfo_sat();
    test_duty_and_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d detections without SSB_start_o, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pss_tracker.md
PSS_TRACKER -- requirements
Module: pss_tracker

Interface
REQ-001 SHALL have parameter SSB_INTERVAL, default 38400, nominal samples between SSB bursts (20 ms at 1.92 Msps).
REQ-002 SHALL have parameter TRACK_TOLERANCE, default 100, half-width in samples of the FIND window.
REQ-003 SHALL have parameter LOCK_HITS, default 2, number of consecutive window hits needed to assert lock.
REQ-004 SHALL have parameter MAX_MISSES, default 3, number of consecutive window misses that return the block to SEARCH.
REQ-005 SHALL have parameter DDS_DW, default 20, width of the CFO DDS increment.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset_ni  input  1  asynchronous, active-low reset.
REQ-009 s_axis_in_tvalid  input  1  sample strobe; one sample per high cycle.
REQ-010 N_id_2_i  input  2  detected PSS index.
REQ-011 N_id_2_valid_i  input  1  single-cycle PSS detection pulse.
REQ-012 CFO_DDS_inc_i  input  DDS_DW  signed residual CFO increment.
REQ-013 CFO_valid_i  input  1  single-cycle pulse qualifying CFO_DDS_inc_i.
REQ-014 mode_o  output  2  detector mode: SEARCH=0, FIND=1, PAUSE=2.
REQ-015 requested_N_id_2_o  output  2  tracked PSS index, valid in FIND.
REQ-016 locked_o  output  1  tracking lock indicator.
REQ-017 SSB_start_o  output  1  single-cycle pulse on each accepted detection.
REQ-018 CFO_DDS_inc_o  output  DDS_DW  signed accumulated CFO correction.

Function
REQ-019 The FSM SHALL have states SEARCH, PAUSE and FIND; mode_o SHALL equal the current state encoding and be registered, so it changes one cycle after the triggering event.
REQ-020 sample_cnt SHALL be $clog2(SSB_INTERVAL+TRACK_TOLERANCE+1) bits wide and SHALL increment only on cycles where s_axis_in_tvalid is high.
REQ-021 SEARCH: on N_id_2_valid_i, the block SHALL latch N_id_2_i into requested_N_id_2_o, set sample_cnt=0, set hits=1 and misses=0, pulse SSB_start_o, and move to PAUSE.
REQ-022 PAUSE: when a counted sample makes sample_cnt reach SSB_INTERVAL-TRACK_TOLERANCE, the block SHALL move to FIND; N_id_2_valid_i SHALL be ignored in PAUSE.
REQ-023 FIND hit: N_id_2_valid_i with N_id_2_i==requested_N_id_2_o SHALL set sample_cnt=0 and misses=0, increment hits (saturating at LOCK_HITS), pulse SSB_start_o, and move to PAUSE.
REQ-024 A FIND detection whose N_id_2_i differs from requested_N_id_2_o SHALL be ignored.
REQ-025 FIND miss: when sample_cnt reaches SSB_INTERVAL+TRACK_TOLERANCE without a hit, the block SHALL set sample_cnt=TRACK_TOLERANCE (preserving nominal timing), clear hits, increment misses, and move to PAUSE.
REQ-026 If a miss brings misses to MAX_MISSES, the block SHALL instead move to SEARCH, clear locked_o, and clear CFO_DDS_inc_o.
REQ-027 A hit and the window-end condition in the same cycle SHALL be treated as a hit.
REQ-028 locked_o SHALL be set in the cycle after hits reaches LOCK_HITS, and SHALL be cleared only by a return to SEARCH or by reset.
REQ-029 On CFO_valid_i (any state), CFO_DDS_inc_o SHALL become CFO_DDS_inc_o+CFO_DDS_inc_i, saturated to [-2^(DDS_DW-1), 2^(DDS_DW-1)-1]; a same-cycle SEARCH-entry clear SHALL take precedence.
REQ-030 Latency from N_id_2_valid_i to SSB_start_o SHALL be 1 cycle.

Reset
REQ-031 Reset SHALL force the state to SEARCH, set mode_o=0, requested_N_id_2_o=0, locked_o=0, SSB_start_o=0, CFO_DDS_inc_o=0, and clear sample_cnt, hits and misses.
REQ-032 Reset asserted mid-window SHALL take effect immediately with no pending SSB_start_o pulse after release.

Structure
REQ-033 The mode encoding (SEARCH/FIND/PAUSE) and SSB_INTERVAL default SHALL live in a shared package used by this block and the PSS detector.
REQ-034 The saturating signed accumulator SHALL be a sub-module, sat_accumulator, parameterised by width.

Verification
REQ-035 Test 1: tvalid every cycle, detection N_id_2=1 at t0 -> SSB_start_o at t0+1, mode_o=PAUSE, and mode_o=FIND after 38300 samples.
REQ-036 Test 2: detections at 38400-sample spacing with LOCK_HITS=2 -> locked_o high after the 2nd hit, requested_N_id_2_o=1.
REQ-037 Test 3: after lock, stop detections -> 3 window closures at 38500, 76900 and 115300 samples after the last hit, then mode_o=SEARCH, locked_o=0, CFO_DDS_inc_o=0.
REQ-038 Test 4: in FIND, detection N_id_2=2 while tracking 1 -> ignored; detection on the exact window-end sample -> counted as a hit.
REQ-039 Test 5: CFO increments +2^19-10 then +100 (DDS_DW=20) -> CFO_DDS_inc_o saturates at 524287; then -5 gives 524282.
REQ-040 Test 6: tvalid 1-in-4 duty -> window timing scales to sample count, not cycles; reset asserted mid-FIND -> all outputs at reset values.
